maxpool_seq: RTL and testbench

Sequencer that drives a running-maximum compare-and-hold datapath to perform 1-D max pooling over a stream of unsigned samples. On `start` it latches a window length and a window count. It then accepts samples over a valid/ready handshake and folds each window into a registered maximum. Each window result is emitted on an output handshake, and a `done` pulse ends the frame. It sits between the feature-buffer read port and the pooled-result write-back in the accelerator datapath.

---
 rtl/pool_pkg.sv | 7 +
 rtl/pool_max_acc.sv | 17 +
 rtl/maxpool_seq.sv | 85 ++++++++
 tb/tb_maxpool_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared state encoding and default widths for the max-pooling sequencer.
package pool_pkg;
  localparam int POOL_DATA_W = 4;
  localparam int POOL_LEN_W  = 4;
  localparam int POOL_NUM_W  = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD, DONE} state_t;
endpackage

// File: rtl/pool_max_acc.sv
// pool_max_acc: running-maximum register; first beat of a window loads unconditionally.
module pool_max_acc
  import pool_pkg::*;
#(
  parameter int W = POOL_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_first,
  input  logic         load_next,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  logic [W-1:0] acc_d;
  always_comb acc_d = load_first ? din : (load_next && din > acc) ? din : acc;
  always_ff @(posedge clk) acc <= !rst ? '0 : acc_d;
endmodule

// File: rtl/maxpool_seq.sv
// maxpool_seq: sequences windows of a sample stream through pool_max_acc and emits each window maximum.
module maxpool_seq
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int LEN_W  = POOL_LEN_W,
  parameter int NUM_W  = POOL_NUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_W-1:0]  out_idx,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, beat_q, beat_d;
  logic [NUM_W-1:0]   num_q, num_d, idx_q, idx_d;
  logic               load_first, load_next;
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    beat_d     = beat_q;
    idx_d      = idx_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        num_d   = cfg_num;
        beat_d  = '0;
        idx_d   = '0;
        state_d = (cfg_num == '0) ? DONE : ACCUM;
      end
      ACCUM: if (in_valid) begin
        load_first = (beat_q == '0);
        load_next  = (beat_q != '0);
        beat_d     = (beat_q == len_q - LEN_W'(1)) ? '0 : beat_q + LEN_W'(1);
        state_d    = (beat_q == len_q - LEN_W'(1)) ? HOLD : ACCUM;
      end
      HOLD: if (out_ready) begin
        idx_d   = (idx_q == num_q - NUM_W'(1)) ? idx_q : idx_q + NUM_W'(1);
        state_d = (idx_q == num_q - NUM_W'(1)) ? DONE : ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      num_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
    end
  end
  pool_max_acc #(.W(DATA_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .load_first (load_first),
    .load_next  (load_next),
    .din        (in_data),
    .acc        (out_data)
  );
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_idx   = idx_q;
endmodule

// File: tb/tb_maxpool_seq.sv
// tb_maxpool_seq: randomized frames checked against a per-window maximum model.
module tb_maxpool_seq;
  logic       clk = 0, rst = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [3:0] cfg_len = 0, in_data = 0;
  logic [7:0] cfg_num = 0;
  logic       in_ready, out_valid, busy, done;
  logic [3:0] out_data;
  logic [7:0] out_idx;
  int checks = 0, errors = 0;
  int samp_q[$];

  maxpool_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_frame(input int len, input int num, input bit gaps, input int stall, input bit poke);
    int eff, mx, s, n;
    bit acc;
    @(negedge clk);
    start = 1; cfg_len = 4'(len); cfg_num = 8'(num);
    @(negedge clk);
    start = 0; cfg_len = 4'($urandom); cfg_num = 8'($urandom);
    chk("busy_after_start", busy, 1);
    if (num == 0) begin
      chk("done_num0", done, 1);
      chk("rdy_num0", in_ready, 0);
      @(negedge clk);
      chk("idle_num0", busy, 0);
      chk("done_num0_end", done, 0);
      return;
    end
    chk("rdy_after_start", in_ready, 1);
    eff = (len == 0) ? 1 : len;
    for (int w = 0; w < num; w++) begin
      mx = -1;
      for (int b = 0; b < eff; b++) begin
        s = (samp_q.size() != 0) ? samp_q.pop_front() : int'($urandom_range(0, 15));
        if (s > mx) mx = s;
        n = 0;
        do begin
          in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          in_data = in_valid ? 4'(s) : 4'($urandom);
          if (poke && w == 0 && b == 0) begin
            start = 1; cfg_len = 4'(len + 3); cfg_num = 8'(num + 5);
          end
          acc = in_valid && in_ready;
          @(negedge clk);
          start = 0;
          n++;
        end while (!acc && n < 50);
        if (!acc) begin
          chk("beat_timeout", 0, 1);
          in_valid = 0;
          return;
        end
      end
      in_valid = 0;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, mx);
      chk("out_idx", out_idx, w);
      chk("hold_rdy", in_ready, 0);
      for (int k = 0; k < stall; k++) begin
        in_valid = 1; in_data = 4'($urandom);
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, mx);
        chk("stall_idx", out_idx, w);
        chk("stall_rdy", in_ready, 0);
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      if (w < num - 1) begin
        chk("bubble_rdy", in_ready, 1);
        chk("bubble_valid", out_valid, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("done_cleared", done, 0);
        chk("busy_cleared", busy, 0);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    rst = 1;
    samp_q = '{1, 3, 2, 0, 5, 5, 4, 7};
    run_frame(4, 2, 0, 0, 0);
    samp_q = '{9, 9, 2, 1};
    run_frame(2, 2, 0, 0, 0);
    run_frame(3, 2, 0, 5, 0);
    samp_q = '{6, 2};
    run_frame(0, 2, 0, 0, 0);
    run_frame(3, 0, 0, 0, 0);
    run_frame(3, 2, 1, 1, 1);
    run_frame(5, 3, 1, 2, 0);
    @(negedge clk);
    start = 1; cfg_len = 4; cfg_num = 1;
    @(negedge clk);
    start = 0; in_valid = 1; in_data = 9;
    @(negedge clk);
    in_data = 11;
    @(negedge clk);
    in_valid = 0; rst = 0;
    @(negedge clk);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    rst = 1;
    samp_q = '{1, 2, 3, 4};
    run_frame(4, 1, 0, 0, 0);
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
